debounce_bank: RTL



---
 rtl/debounce_bank.sv | 117 +++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: 2-flop sync, polarity mask, restart-on-bounce debounce, press/release strobes.
// Defining DEBOUNCE_BANK_REPEAT_EN adds hold-to-repeat strobes on BTN_REPEAT; otherwise BTN_REPEAT is tied low.
module debounce_bank #(
    parameter int                  CHANNELS      = 5,
    parameter int                  TIMEOUT       = 1000000,
    parameter logic [CHANNELS-1:0] INVERT        = '0,
    parameter int                  HOLD_CYCLES   = 50000000,
    parameter int                  REPEAT_CYCLES = 10000000
) (
    input  logic                CLK,
    input  logic                CPU_RESETN,
    input  logic [CHANNELS-1:0] BTN_IN,
    output logic [CHANNELS-1:0] BTN_STATE,
    output logic [CHANNELS-1:0] BTN_RISE,
    output logic [CHANNELS-1:0] BTN_FALL,
    output logic [CHANNELS-1:0] BTN_REPEAT
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int            HMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int            HW        = $clog2(HMAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] level;

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= BTN_IN;
            sync2_q <= sync1_q;
        end
    end

    // Polarity is applied after synchronisation so every channel debounces "pressed = 1".
    assign level = sync2_q ^ INVERT;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [CW-1:0] cnt_q;
        logic          state_q;
        logic          rise_q;
        logic          fall_q;
        logic          flip;

        assign flip = (level[i] != state_q) && (cnt_q == CNT_LAST);

        always_ff @(posedge CLK or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                cnt_q   <= '0;
                state_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= flip & level[i];
                fall_q <= flip & ~level[i];
                // Any sample matching the current state restarts the count, so bounces never accumulate.
                if ((level[i] == state_q) || flip) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (flip) begin
                    state_q <= level[i];
                end
            end
        end

        assign BTN_STATE[i] = state_q;
        assign BTN_RISE[i]  = rise_q;
        assign BTN_FALL[i]  = fall_q;

`ifdef DEBOUNCE_BANK_REPEAT_EN
        logic [HW-1:0] hold_q;
        logic          phase_q;
        logic          rep_q;
        logic [HW-1:0] hold_target;

        assign hold_target = phase_q ? REP_LAST : HOLD_LAST;

        // A flip in either direction clears the hold timer, so repeats never coincide with RISE or FALL.
        always_ff @(posedge CLK or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                hold_q  <= '0;
                phase_q <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (flip || !state_q) begin
                    hold_q  <= '0;
                    phase_q <= 1'b0;
                end else if (hold_q == hold_target) begin
                    rep_q   <= 1'b1;
                    hold_q  <= '0;
                    phase_q <= 1'b1;
                end else begin
                    hold_q <= hold_q + 1'b1;
                end
            end
        end

        assign BTN_REPEAT[i] = rep_q;
`endif
    end

`ifndef DEBOUNCE_BANK_REPEAT_EN
    assign BTN_REPEAT = '0;
`endif

endmodule
